// File: rtl/ft245_responder.sv
// rtl/ft245_responder.sv - FT245-style async FIFO bus device-side responder with loopback/local queue
module ft245_responder #(
    parameter int DEPTH          = 16,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    inout  wire  [7:0]               data_io,
    output logic                     nRXF_o,
    output logic                     nTXE_o,
    input  logic                     nRD_i,
    input  logic                     nWR_i,
    input  logic                     loopback_i,
    input  logic [7:0]               push_data_i,
    input  logic                     push_valid_i,
    output logic                     push_ready_o,
    output logic [7:0]               wr_data_o,
    output logic                     wr_valid_o,
    output logic [$clog2(DEPTH):0]   fill_o,
    output logic                     overflow_o,
    output logic                     underflow_o,
    output logic                     proto_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RECOVER_CYCLES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_READ    = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_RECOVER = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] rcnt;
    logic          rd_s1, rd_s2, rd_prev;
    logic          wr_s1, wr_s2, wr_prev;
    logic [7:0]    data_s1, data_s2;
    logic [7:0]    wr_byte;
    logic          rd_have;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;

    logic rd_fall, rd_rise, wr_fall, wr_rise;
    logic empty, full, drive;
    logic do_pop, do_push_local, do_push_lb, enq;
    logic [7:0] enq_data;

    // Sync flops reset low so a strobe already low at reset release never looks like a new falling edge.
    assign rd_fall = rd_prev & ~rd_s2;
    assign rd_rise = ~rd_prev & rd_s2;
    assign wr_fall = wr_prev & ~wr_s2;
    assign wr_rise = ~wr_prev & wr_s2;

    assign empty = (fill_o == '0);
    assign full  = (fill_o == (AW+1)'(DEPTH));

    assign nRXF_o       = (state != S_IDLE) | empty;
    assign nTXE_o       = (state != S_IDLE) | (loopback_i & full);
    assign push_ready_o = ~loopback_i & ~full;

    // Bus is let go combinationally in the cycle the read strobe's rising edge is seen.
    assign drive   = (state == S_READ) & rd_have & ~rd_rise;
    assign data_io = drive ? mem[rptr] : 8'bz;

    assign do_pop        = (state == S_READ) & rd_rise & rd_have;
    assign do_push_local = push_valid_i & push_ready_o;
    assign do_push_lb    = (state == S_WRITE) & wr_rise & loopback_i & ~full;
    assign enq           = do_push_local | do_push_lb;
    assign enq_data      = do_push_lb ? wr_byte : push_data_i;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr] <= enq_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= S_IDLE;
            rcnt        <= '0;
            rd_s1       <= 1'b0;
            rd_s2       <= 1'b0;
            rd_prev     <= 1'b0;
            wr_s1       <= 1'b0;
            wr_s2       <= 1'b0;
            wr_prev     <= 1'b0;
            data_s1     <= '0;
            data_s2     <= '0;
            wr_byte     <= '0;
            rd_have     <= 1'b0;
            wptr        <= '0;
            rptr        <= '0;
            fill_o      <= '0;
            wr_data_o   <= '0;
            wr_valid_o  <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            rd_s1   <= nRD_i;
            rd_s2   <= rd_s1;
            rd_prev <= rd_s2;
            wr_s1   <= nWR_i;
            wr_s2   <= wr_s1;
            wr_prev <= wr_s2;
            data_s1 <= data_io;
            data_s2 <= data_s1;
            wr_valid_o <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rd_fall) begin
                        state   <= S_READ;
                        rd_have <= ~empty;
                        if (empty) begin
                            underflow_o <= 1'b1;
                        end
                    end else if (wr_fall) begin
                        state   <= S_WRITE;
                        wr_byte <= data_s2;
                    end
                end
                S_READ: begin
                    if (rd_rise) begin
                        state <= S_RECOVER;
                        rcnt  <= CW'(RECOVER_CYCLES - 1);
                    end
                end
                S_WRITE: begin
                    if (wr_rise) begin
                        state <= S_RECOVER;
                        rcnt  <= CW'(RECOVER_CYCLES - 1);
                        if (loopback_i) begin
                            if (full) begin
                                overflow_o <= 1'b1;
                            end
                        end else begin
                            wr_valid_o <= 1'b1;
                            wr_data_o  <= wr_byte;
                        end
                    end
                end
                default: begin
                    if (rcnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        rcnt <= rcnt - 1'b1;
                    end
                end
            endcase

            if ((rd_fall | wr_fall) & ~rd_s2 & ~wr_s2) begin
                proto_err_o <= 1'b1;
            end

            if (enq) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({enq, do_pop})
                2'b10:   fill_o <= fill_o + 1'b1;
                2'b01:   fill_o <= fill_o - 1'b1;
                default: fill_o <= fill_o;
            endcase
        end
    end
endmodule

// File: doc/ft245_responder.md
Name: ft245_responder

Overview:
- Device-side responder for the FT245-style asynchronous FIFO bus that the FPGA-side fifo_interface drives: it drives nRXF/nTXE, answers nRD/nWR strobes, and sources/sinks bytes on the shared data bus.
- Used as an in-fabric or second-board stand-in for the FT2232H so the sample-stream framing (byte with MSB=1 carries bits 13:7, then byte with MSB=0 carries bits 6:0) can be exercised without a PC.
- Provides loopback (written bytes are queued for read-back) or a local push/pop side for bench stimulus.

Parameters:
- DEPTH, 16, read-queue depth in bytes; power of two, minimum 2.
- RECOVER_CYCLES, 4, clocks nRXF_o/nTXE_o are held high after each completed strobe.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- data_io  inout  8  FT245 data bus; driven only during a read strobe
- nRXF_o  out  1  low = byte available for master to read
- nTXE_o  out  1  low = master may write a byte
- nRD_i  in  1  master read strobe, active low, asynchronous
- nWR_i  in  1  master write strobe, active low, asynchronous
- loopback_i  in  1  1 = written bytes enter the read queue; 0 = written bytes go to wr_data_o
- push_data_i  in  8  local byte to enqueue for master reads (loopback_i=0 only)
- push_valid_i  in  1  enqueue request
- push_ready_o  out  1  queue not full and loopback_i=0
- wr_data_o  out  8  byte received from master
- wr_valid_o  out  1  one-cycle pulse with wr_data_o (loopback_i=0 only)
- fill_o  out  $clog2(DEPTH)+1  read-queue occupancy
- overflow_o  out  1  sticky: write while queue full
- underflow_o  out  1  sticky: read while queue empty
- proto_err_o  out  1  sticky: nRD and nWR both low

Behaviour:
- Reset: queue empty, fill_o=0, nRXF_o=1, nTXE_o=1, data bus released, wr_valid_o=0, wr_data_o=0, all sticky flags 0, state IDLE. A reset mid-strobe releases the bus on the next edge and ignores the strobe in progress.
- nRD_i, nWR_i and data_io pass through two-flop synchronizers. Edges are detected on the synchronized strobes, so latency from a pin edge to detection is 2–3 clocks.
- States:
  - IDLE: nRXF_o = (queue empty), i.e. low when the queue holds a byte. nTXE_o = 0 if loopback_i=0, or if loopback_i=1 and the queue is not full; otherwise 1.
  - IDLE -> READ on a synchronized nRD falling edge.
  - IDLE -> WRITE on a synchronized nWR falling edge.
  - READ: drive the head byte onto data_io from the first READ cycle. On synchronized nRD rising: release the bus in the same cycle, pop the head, go to RECOVER.
  - WRITE: capture the synchronized data on entry. On synchronized nWR rising: commit the byte (enqueue if loopback_i=1, else wr_valid_o pulse for 1 cycle), go to RECOVER.
  - RECOVER: nRXF_o=1 and nTXE_o=1 for RECOVER_CYCLES clocks, then IDLE.
- nRXF_o/nTXE_o are forced high in every state other than IDLE.
- Read when queue empty: data_io stays released, no pop, underflow_o set; FSM still goes READ -> RECOVER.
- Write when the queue is full (loopback): byte dropped, overflow_o set; FSM still goes WRITE -> RECOVER.
- nRD and nWR falling in the same cycle: proto_err_o set, read takes priority, the write is ignored.
- Local push (loopback_i=0): accepted when push_valid_i & push_ready_o. A push and a pop in the same cycle keep fill_o unchanged. push_ready_o=0 while loopback_i=1.
- Pointers wrap modulo DEPTH. fill_o ranges 0..DEPTH.
- Changing loopback_i mid-strobe takes effect only at the commit of that strobe.
- Master contract: do not drive data_io until at least 3 clocks after nRD rises (bus release latency).

Test Plan:
- Loopback echo: loopback_i=1; master writes 0x85 then 0x2A -> fill_o=2, nRXF_o low after RECOVER; two reads return 0x85 then 0x2A on data_io; fill_o=0; nRXF_o high.
- Local stream: loopback_i=0; push 0xC0, 0x11 -> master reads 0xC0, 0x11. Master writes 0x7F -> wr_valid_o pulses once with wr_data_o=0x7F, fill_o unchanged.
- Full/overflow: loopback_i=1; DEPTH writes -> nTXE_o stays high in IDLE; a forced extra write of 0x55 -> overflow_o=1, queue contents unchanged, fill_o=DEPTH.
- Underflow: empty queue; master pulses nRD -> data_io stays Z throughout, underflow_o=1, fill_o=0.
- Recover timing and collision: after any strobe, nRXF_o and nTXE_o are high for exactly RECOVER_CYCLES=4 clocks. Simultaneous nRD/nWR falling with queue holding 0x9A -> read returns 0x9A, proto_err_o=1, no enqueue.
- Reset mid-read: assert reset_i while nRD is low and the bus is driven -> bus released next edge, fill_o=0, nRXF_o=1, all flags 0.
